// File: rtl/sort_pkg.sv
// Shared frame geometry and loader state encoding for the sorter front end.
package sort_pkg;

    localparam int unsigned SORT_N     = 6;
    localparam int unsigned SORT_WIDTH = 8;

    typedef enum logic [1:0] {
        COLLECT   = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/sort_loader.sv
// Collects N streamed elements into a parallel frame, launches the sorter with a
// one-cycle start pulse and holds the frame until sort_done, guarded by a watchdog.
module sort_loader
    import sort_pkg::*;
#(
    parameter int unsigned N           = SORT_N,
    parameter int unsigned WIDTH       = SORT_WIDTH,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    input  logic                      flush,
    output logic [N-1:0][WIDTH-1:0]   data_out,
    output logic                      start,
    input  logic                      sort_done,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC);

    loader_state_t            state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [WD_W-1:0]          wd_q, wd_d;
    logic [N-1:0][WIDTH-1:0]  data_q, data_d;
    logic                     err_q, err_d;
    logic                     ready_q, ready_d;
    logic                     start_q, start_d;
    logic                     busy_q, busy_d;

    // State register; the handshake outputs are registered copies of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            wd_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            data_q  <= data_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            start_q <= start_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wd_d    = wd_q;
        data_d  = data_q;
        err_d   = err_q;

        unique case (state_q)
            COLLECT: begin
                if (flush) begin
                    idx_d = '0;
                    err_d = 1'b0;
                end else if (in_valid && ready_q) begin
                    data_d[idx_q] = in_data;
                    if (idx_q == IDX_W'(N - 1)) begin
                        idx_d   = '0;
                        state_d = LAUNCH;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            LAUNCH: begin
                wd_d    = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                wd_d = wd_q + WD_W'(1);
                // Completion outranks a same-cycle watchdog expiry.
                if (sort_done) begin
                    state_d = COLLECT;
                end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase

        ready_d = (state_d == COLLECT);
        start_d = (state_d == LAUNCH);
        busy_d  = (state_d != COLLECT);
    end

    assign in_ready    = ready_q;
    assign start       = start_q;
    assign busy        = busy_q;
    assign timeout_err = err_q;
    assign data_out    = data_q;

endmodule

// File: tb/tb_sort_loader.sv
// Self-checking bench for sort_loader: table of frames with done delays plus
// hand-written flush, spurious-done and mid-wait reset sequences.
module tb_sort_loader;

    localparam int unsigned N  = 6;
    localparam int unsigned W  = 8;
    localparam int unsigned TO = 64;
    localparam int unsigned FW = N * W;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic [W-1:0]          in_data = '0;
    logic                  flush = 1'b0;
    logic                  sort_done = 1'b0;
    logic                  in_ready;
    logic [N-1:0][W-1:0]   data_out;
    logic                  start;
    logic                  busy;
    logic                  timeout_err;

    int checks = 0;
    int errors = 0;
    logic [FW-1:0] sb_q[$];
    logic          exp_err = 1'b0;
    logic [FW-1:0] last_frame = '0;

    typedef struct {
        logic [FW-1:0] frame;
        int            done_dly;   // cycles from start to sort_done; -1 = never
    } vec_t;

    vec_t vecs[5];

    sort_loader #(.N(N), .WIDTH(W), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .flush      (flush),
        .data_out   (data_out),
        .start      (start),
        .sort_done  (sort_done),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mk(input int a, input int b, input int c,
                                         input int d, input int e, input int f);
        return {W'(f), W'(e), W'(d), W'(c), W'(b), W'(a)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted; reports cycles spent waiting.
    task automatic send_beat(input logic [W-1:0] d, output int waits);
        waits = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && waits < 200) begin
            step();
            waits++;
        end
        if (waits >= 200) chk("beat_accept_timeout", 64'(waits), 64'd0);
        step();
    endtask

    // Stream a frame, check the launch, hold through WAIT_DONE and finish it.
    task automatic run_frame(input logic [FW-1:0] fr, input int dly);
        int waits;
        int lim;
        logic [FW-1:0] exp;
        sb_q.push_back(fr);
        for (int i = 0; i < int'(N); i++) begin
            send_beat(fr[i*W +: W], waits);
            chk("beat_wait", 64'(waits), 64'd0);
        end
        in_valid = 1'b0;
        chk("start_pulse", 64'(start), 64'd1);
        chk("busy_launch", 64'(busy), 64'd1);
        chk("ready_launch", 64'(in_ready), 64'd0);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        chk("frame_data", 64'(data_out), 64'(exp));
        last_frame = exp;
        step();
        lim = (dly < 0) ? int'(TO) : dly;
        for (int k = 1; k < lim; k++) begin
            chk("wait_state", {data_out, start, busy, in_ready}, {exp, 1'b0, 1'b1, 1'b0});
            step();
        end
        chk("wait_last", {data_out, busy, timeout_err}, {exp, 1'b1, exp_err});
        if (dly > 0) sort_done = 1'b1;
        step();
        sort_done = 1'b0;
        if (dly < 0) exp_err = 1'b1;
        chk("after_wait", {in_ready, busy, start, timeout_err}, {1'b1, 1'b0, 1'b0, exp_err});
    endtask

    initial begin
        int waits;
        vecs[0] = '{frame: mk(5, 3, 9, 1, 7, 2),           done_dly: 9};
        vecs[1] = '{frame: mk(1, 2, 3, 4, 5, 6),           done_dly: 9};
        vecs[2] = '{frame: mk(255, 0, 128, 127, 1, 254),   done_dly: 1};
        vecs[3] = '{frame: mk(42, 43, 44, 45, 46, 47),     done_dly: int'(TO)};
        vecs[4] = '{frame: mk(9, 8, 7, 6, 5, 4),           done_dly: -1};

        in_valid = 1'b1;
        in_data  = 8'hAA;
        step();
        step();
        chk("reset_vals", {data_out, start, busy, timeout_err}, {FW'(0), 3'b000});
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("ready_after_release", {in_ready, busy, start}, 3'b100);

        for (int v = 0; v < 5; v++) run_frame(vecs[v].frame, vecs[v].done_dly);

        // Spurious sort_done in COLLECT is ignored; flush then clears the sticky error.
        sort_done = 1'b1;
        step();
        sort_done = 1'b0;
        chk("spurious_done", {in_ready, busy, start, timeout_err}, 4'b1001);
        flush = 1'b1;
        step();
        flush = 1'b0;
        exp_err = 1'b0;
        chk("flush_clears_err", 64'(timeout_err), 64'd0);

        // Partial frame, then flush with a same-cycle valid beat.
        for (int i = 0; i < 3; i++) send_beat(W'(20 + i), waits);
        in_data = 8'd99;
        flush   = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_keeps_elem0", 64'(data_out[0]), 64'd20);
        chk("flush_keeps_elem3", 64'(data_out[3]), 64'(last_frame[3*W +: W]));
        chk("flush_no_start", {start, busy, in_ready}, 3'b001);
        run_frame(mk(10, 11, 12, 13, 14, 15), 3);

        // Reset in the middle of WAIT_DONE with random upstream activity.
        sb_q.push_back(mk(31, 32, 33, 34, 35, 36));
        for (int i = 0; i < int'(N); i++) send_beat(W'(31 + i), waits);
        chk("rst_seq_start", 64'(start), 64'd1);
        chk("rst_seq_data", 64'(data_out), 64'(sb_q.pop_front()));
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = W'($urandom_range(0, 255));
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midwait_reset", {data_out, start, busy, timeout_err}, {FW'(0), 3'b000});
        step();
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("ready_after_rst2", {in_ready, busy, start}, 3'b100);
        run_frame(mk(100, 90, 80, 70, 60, 50), 4);

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sort_loader.md
Name: sort_loader

Overview:
- Upstream feeder for the fixed-size sorter stage.
- Accepts a stream of WIDTH-bit elements over a valid/ready handshake and assembles N of them into a parallel frame.
- Launches the sorter with a one-cycle start pulse, then holds the frame stable until the sorter reports done.
- A watchdog flags a sorter that never completes; a flush input discards a partially collected frame.

Parameters:
N, 6, elements per frame (must match the sorter's N)
WIDTH, 8, bits per element
TIMEOUT_CYC, 64, max cycles to wait for sort_done before declaring timeout (>= 16)

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream element valid
in_data  input  WIDTH  upstream element
in_ready  output  1  loader accepts an element this cycle
flush  input  1  discard partial frame / clear error (COLLECT only)
data_out  output  N x WIDTH  parallel frame to the sorter's data inputs, element 0 = first accepted
start  output  1  one-cycle launch pulse to the sorter
sort_done  input  1  sorter completion pulse
busy  output  1  high in LAUNCH and WAIT_DONE
timeout_err  output  1  sticky watchdog error

Behaviour:
- Reset (rst_n low, asynchronous): state=COLLECT, idx=0, data_out all 0, start=0, busy=0, timeout_err=0, watchdog=0. in_ready=1 from the first clock after reset release.
- States: COLLECT, LAUNCH, WAIT_DONE (enum in package). All outputs are registered or decoded directly from state; no input-to-output combinational path.
- COLLECT:
  - in_ready=1.
  - Handshake when in_valid && in_ready: data_out[idx] <= in_data, idx++.
  - When the accepted beat has idx==N-1: idx <= 0, go to LAUNCH.
  - flush=1 takes priority over a same-cycle handshake: idx <= 0, timeout_err <= 0, beat dropped, data_out left unchanged.
  - sort_done ignored.
- LAUNCH:
  - start=1 for exactly this one cycle; in_ready=0; busy=1; watchdog <= 0.
  - Always goes to WAIT_DONE.
  - Latency: last beat accepted at edge t gives start high during cycle t+1.
- WAIT_DONE:
  - start=0, in_ready=0, busy=1.
  - data_out is held constant; the sorter reads it combinationally over several cycles.
  - watchdog increments each cycle.
  - sort_done=1: go to COLLECT; in_ready=1 the following cycle.
  - Otherwise, if watchdog==TIMEOUT_CYC-1: timeout_err <= 1 (sticky), go to COLLECT.
  - If sort_done and timeout coincide, done wins; timeout_err stays unchanged.
  - flush ignored.
- start is never high on two consecutive cycles. This guarantees a clean rising edge for the sorter's edge detector.
- Back-to-back frames: the first beat of the next frame can be accepted the cycle after sort_done is sampled.
- in_valid without a handshake (in_ready=0) is held by upstream; the loader never drops a valid beat except on flush.
- Reset asserted mid-frame or mid-wait: immediate return to reset values. A sorter in progress is not notified; it is reset by the same rst domain.
- Widths: idx is $clog2(N) bits; watchdog is $clog2(TIMEOUT_CYC) bits and saturates only via the state exit.

Decomposition:
- Package sort_pkg holds:
  - loader_state_t enum {COLLECT, LAUNCH, WAIT_DONE}
  - default constants SORT_N=6, SORT_WIDTH=8, so that loader and sorter share frame geometry.
- No sub-module: the watchdog is a single counter and stays inline.
- Whole block is one flat module of roughly 150 lines.

Test Plan:
- Reset then stream 5,3,9,1,7,2 with in_valid continuous -> in_ready high for 6 cycles; data_out={5,3,9,1,7,2}; start high exactly 1 cycle, the cycle after beat 6; busy=1.
- Hold data stable, pulse sort_done 9 cycles after start -> data_out unchanged throughout WAIT_DONE; in_ready=1 the cycle after sort_done; second frame 1..6 accepted back-to-back with a second single start pulse.
- Accept 3 beats, assert flush with in_valid=1 -> that beat dropped, idx=0; next 6 beats 10..15 form data_out={10,11,12,13,14,15}.
- Launch, never assert sort_done -> timeout_err=1 after TIMEOUT_CYC=64 wait cycles; state back to COLLECT; a subsequent flush clears timeout_err to 0.
- sort_done and timeout in the same cycle -> COLLECT, timeout_err stays 0; a spurious sort_done during COLLECT has no effect.
- Deassert rst_n mid-WAIT_DONE with a random in_valid pattern -> all outputs at reset values immediately; in_ready=1 after release.
